// File: rtl/crc_pkg.sv
// Shared types and defaults for the serial CRC checker family.
// Zero-init, unreflected, no final XOR; must match the parallel generator.
package crc_pkg;

    localparam int          CRC_BW_DEF  = 8;
    localparam int          BW_DEF      = 40;
    localparam logic [7:0]  DIVISOR_DEF = 8'h07;

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        DONE
    } state_e;

    function automatic int frame_len(input int bw, input int crc_bw);
        return bw + crc_bw;
    endfunction

endpackage

// File: rtl/crc_lfsr_step.sv
// One bit of serial polynomial division: rem' = (rem * x + b) mod P.
// Purely combinational so a future serial generator can share it.
module crc_lfsr_step #(
    parameter int CRC_BW = 8
) (
    input  logic [CRC_BW-1:0] rem_in,
    input  logic              bit_in,
    input  logic [CRC_BW-1:0] divisor,
    output logic [CRC_BW-1:0] rem_out
);

    logic fb;

    assign fb      = rem_in[CRC_BW-1];
    assign rem_out = {rem_in[CRC_BW-2:0], bit_in} ^ ({CRC_BW{fb}} & divisor);

endmodule

// File: rtl/crc_checker.sv
// Bit-serial CRC checker: captures BW payload + CRC_BW check bits (MSB first)
// and reports the received fields with a zero-remainder pass flag.
module crc_checker
    import crc_pkg::*;
#(
    parameter int                BW      = BW_DEF,
    parameter int                CRC_BW  = CRC_BW_DEF,
    parameter logic [CRC_BW-1:0] DIVISOR = CRC_BW'(DIVISOR_DEF)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_bit,
    input  logic              in_valid,
    input  logic              in_sof,
    output logic              in_ready,
    output logic [BW-1:0]     payload,
    output logic [CRC_BW-1:0] crc_rx,
    output logic              crc_ok,
    output logic              frame_done,
    output logic              frame_abort,
    output logic              busy
);

    localparam int FL = frame_len(BW, CRC_BW);
    localparam int CW = $clog2(FL + 1);

    state_e              state_q;
    logic [CRC_BW-1:0]   rem_q;
    logic [CRC_BW-1:0]   rem_d;
    logic [CRC_BW-1:0]   rem_base;
    logic [CW-1:0]       cnt_q;
    logic [FL-1:0]       frame_q;
    logic [FL-1:0]       frame_d;
    logic [BW-1:0]       payload_q;
    logic [CRC_BW-1:0]   crc_rx_q;
    logic                crc_ok_q;
    logic                done_q;
    logic                abort_q;
    logic                accept;
    logic                restart;

    assign in_ready = (state_q != DONE);
    assign busy     = (state_q != IDLE);
    assign accept   = in_valid && in_ready;
    assign restart  = accept && in_sof;

    // A start-of-frame bit divides from a zero remainder, whatever came before.
    assign rem_base = restart ? '0 : rem_q;
    assign frame_d  = restart ? FL'(in_bit) : {frame_q[FL-2:0], in_bit};

    crc_lfsr_step #(
        .CRC_BW (CRC_BW)
    ) u_step (
        .rem_in  (rem_base),
        .bit_in  (in_bit),
        .divisor (DIVISOR),
        .rem_out (rem_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            rem_q     <= '0;
            cnt_q     <= '0;
            frame_q   <= '0;
            payload_q <= '0;
            crc_rx_q  <= '0;
            crc_ok_q  <= 1'b0;
            done_q    <= 1'b0;
            abort_q   <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            abort_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (restart) begin
                        rem_q   <= rem_d;
                        frame_q <= frame_d;
                        cnt_q   <= CW'(1);
                        state_q <= RECV;
                    end
                end
                RECV: begin
                    if (accept) begin
                        rem_q   <= rem_d;
                        frame_q <= frame_d;
                        if (in_sof) begin
                            cnt_q   <= CW'(1);
                            abort_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                            // Final bit: publish results together with the pulse.
                            if (cnt_q == CW'(FL - 1)) begin
                                state_q   <= DONE;
                                done_q    <= 1'b1;
                                payload_q <= frame_d[FL-1:CRC_BW];
                                crc_rx_q  <= frame_d[CRC_BW-1:0];
                                crc_ok_q  <= (rem_d == '0);
                            end
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign payload     = payload_q;
    assign crc_rx      = crc_rx_q;
    assign crc_ok      = crc_ok_q;
    assign frame_done  = done_q;
    assign frame_abort = abort_q;

endmodule

// File: tb/tb_crc_checker.sv
// Directed plus random frames for crc_checker, checked against a
// whole-frame polynomial long-division reference.
module tb_crc_checker;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_bit = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_sof = 1'b0;
    logic        in_ready;
    logic [39:0] payload;
    logic [7:0]  crc_rx;
    logic        crc_ok;
    logic        frame_done;
    logic        frame_abort;
    logic        busy;

    int n_assert = 0;
    int n_fail   = 0;
    int n_done   = 0;

    crc_checker dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_bit      (in_bit),
        .in_valid    (in_valid),
        .in_sof      (in_sof),
        .in_ready    (in_ready),
        .payload     (payload),
        .crc_rx      (crc_rx),
        .crc_ok      (crc_ok),
        .frame_done  (frame_done),
        .frame_abort (frame_abort),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst_n && frame_done) n_done <= n_done + 1;
    end

    // Remainder of the frame polynomial modulo x^8+x^2+x+1.
    function automatic logic [7:0] poly_mod(input logic [63:0] v);
        for (int i = 63; i >= 8; i--) begin
            if (v[i]) v = v ^ (64'h107 << (i - 8));
        end
        return v[7:0];
    endfunction

    function automatic logic [47:0] make_frame(input logic [39:0] p);
        return {p, poly_mod({16'h0, p, 8'h00})};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b, input logic sof, output int waits);
        @(negedge clk);
        in_valid = 1'b1;
        in_bit   = b;
        in_sof   = sof;
        waits    = 0;
        while (!in_ready && waits < 4) begin
            @(negedge clk);
            waits++;
        end
        if (waits >= 4) chk("ready_timeout", {63'd0, in_ready}, 64'd1);
    endtask

    task automatic send_frame(input logic [47:0] f, input int gap_at);
        int w;
        for (int i = 47; i >= 0; i--) begin
            if (i == gap_at) begin
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    in_valid = 1'b0;
                    chk("gap_busy", {63'd0, busy}, 64'd1);
                    chk("gap_done", {63'd0, frame_done}, 64'd0);
                end
            end
            send_bit(f[i], (i == 47), w);
            if (i == 0) chk("done_early", {63'd0, frame_done}, 64'd0);
        end
    endtask

    task automatic check_done(input logic [47:0] f);
        chk("done_pulse", {63'd0, frame_done}, 64'd1);
        chk("payload", {24'd0, payload}, {24'd0, f[47:8]});
        chk("crc_rx", {56'd0, crc_rx}, {56'd0, f[7:0]});
        chk("crc_ok", {63'd0, crc_ok}, {63'd0, (poly_mod({16'h0, f}) == 8'h00)});
        chk("done_ready", {63'd0, in_ready}, 64'd0);
        chk("done_busy", {63'd0, busy}, 64'd1);
    endtask

    task automatic finish_frame(input logic [47:0] f);
        @(negedge clk);
        in_valid = 1'b0;
        in_sof   = 1'b0;
        check_done(f);
        @(negedge clk);
        chk("done_one_cycle", {63'd0, frame_done}, 64'd0);
        chk("idle_busy", {63'd0, busy}, 64'd0);
        chk("idle_ready", {63'd0, in_ready}, 64'd1);
    endtask

    initial begin
        logic [47:0] f;
        logic [47:0] f2;
        logic [39:0] p;
        int          w;
        int          nd;

        repeat (2) @(negedge clk);
        chk("rst_payload", {24'd0, payload}, 64'd0);
        chk("rst_crc_rx", {56'd0, crc_rx}, 64'd0);
        chk("rst_crc_ok", {63'd0, crc_ok}, 64'd0);
        chk("rst_done", {63'd0, frame_done}, 64'd0);
        chk("rst_abort", {63'd0, frame_abort}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_ready", {63'd0, in_ready}, 64'd1);
        rst_n = 1'b1;

        f = {40'h00_0000_0001, 8'h07};
        send_frame(f, -1);
        finish_frame(f);

        f = {40'h00_0000_00FF, 8'hF3};
        send_frame(f, int'($urandom_range(40, 5)));
        finish_frame(f);

        f = {40'h00_0000_00FF, 8'hF2};
        send_frame(f, -1);
        finish_frame(f);

        f = {40'h00_0000_00FF ^ (40'h1 << 20), 8'hF3};
        send_frame(f, -1);
        finish_frame(f);

        nd = n_done;
        p  = {8'($urandom), 32'($urandom)};
        f2 = make_frame(p);
        for (int i = 0; i < 16; i++) send_bit(f2[47 - i], (i == 0), w);
        send_bit(1'b0, 1'b1, w);
        @(negedge clk);
        in_valid = 1'b0;
        in_sof   = 1'b0;
        chk("abort_pulse", {63'd0, frame_abort}, 64'd1);
        chk("abort_no_done", {63'd0, frame_done}, 64'd0);
        chk("abort_busy", {63'd0, busy}, 64'd1);
        chk("abort_hold", {24'd0, payload}, {24'd0, f[47:8]});
        @(negedge clk);
        chk("abort_one_cycle", {63'd0, frame_abort}, 64'd0);
        for (int i = 46; i >= 0; i--) send_bit(1'b0, 1'b0, w);
        finish_frame(48'h0);
        chk("abort_done_cnt", 64'(n_done), 64'(nd + 1));

        f  = make_frame({8'($urandom), 32'($urandom)});
        f2 = make_frame({8'($urandom), 32'($urandom)});
        send_frame(f, -1);
        @(negedge clk);
        in_valid = 1'b1;
        in_bit   = f2[47];
        in_sof   = 1'b1;
        check_done(f);
        @(negedge clk);
        chk("b2b_ready", {63'd0, in_ready}, 64'd1);
        chk("b2b_idle", {63'd0, busy}, 64'd0);
        for (int i = 46; i >= 0; i--) begin
            send_bit(f2[i], 1'b0, w);
            if (i == 46) chk("b2b_wait", 64'(w), 64'd0);
        end
        finish_frame(f2);

        f = make_frame({8'($urandom), 32'($urandom)});
        for (int i = 47; i >= 18; i--) send_bit(f[i], (i == 47), w);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        nd       = n_done;
        #1;
        chk("mrst_payload", {24'd0, payload}, 64'd0);
        chk("mrst_crc_rx", {56'd0, crc_rx}, 64'd0);
        chk("mrst_crc_ok", {63'd0, crc_ok}, 64'd0);
        chk("mrst_busy", {63'd0, busy}, 64'd0);
        chk("mrst_ready", {63'd0, in_ready}, 64'd1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("mrst_no_done", 64'(n_done), 64'(nd));
        chk("mrst_no_abort", {63'd0, frame_abort}, 64'd0);
        f = make_frame({8'($urandom), 32'($urandom)});
        send_frame(f, -1);
        finish_frame(f);

        for (int r = 0; r < 6; r++) begin
            f = make_frame({8'($urandom), 32'($urandom)});
            if (r % 2 == 1) f = f ^ (48'h1 << $urandom_range(47, 0));
            send_frame(f, (r == 2) ? 30 : -1);
            finish_frame(f);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
